// File: rtl/demux_frame_sequencer_if.sv
// Handshake bundle between the frame source and the demux frame sequencer.
// "master" is the upstream side that drives the serial line. "slave" is the sequencer.
interface demux_frame_sequencer_if;
    logic       din;
    logic       din_valid;
    logic [2:0] sel;
    logic       dout;
    logic       dout_valid;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    modport master (
        output din, din_valid,
        input  sel, dout, dout_valid, busy, frame_done, frame_err
    );

    modport slave (
        input  din, din_valid,
        output sel, dout, dout_valid, busy, frame_done, frame_err
    );
endinterface

// File: rtl/demux_frame_sequencer.sv
// Decodes framed serial input: start(1), 3-bit address, payload, stop(0).
// It drives the channel select and the serial data input of a 1-to-8 demux.
module demux_frame_sequencer #(
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    demux_frame_sequencer_if.slave  bus
);
    localparam int CW = $clog2(PAYLOAD_BITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      acnt_q, acnt_d;
    logic [1:0]      ashd_q, ashd_d;
    logic [CW-1:0]   pcnt_q, pcnt_d;
    logic [2:0]      sel_q, sel_d;
    logic            dout_q, dout_d;
    logic            dv_q, dv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acnt_q  <= '0;
            ashd_q  <= '0;
            pcnt_q  <= '0;
            sel_q   <= '0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acnt_q  <= acnt_d;
            ashd_q  <= ashd_d;
            pcnt_q  <= pcnt_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Strobes default low, so a stall cycle or an idle cycle shows zeros to the demux.
    always_comb begin
        state_d = state_q;
        acnt_d  = acnt_q;
        ashd_d  = ashd_q;
        pcnt_d  = pcnt_q;
        sel_d   = sel_q;
        dout_d  = 1'b0;
        dv_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.din_valid) begin
            unique case (state_q)
                IDLE: if (bus.din) begin
                    state_d = ADDR;
                    acnt_d  = '0;
                    pcnt_d  = '0;
                end
                ADDR: begin
                    if (acnt_q == 2'd2) begin
                        // Load the whole address at once so sel never shows a partial address.
                        sel_d   = {ashd_q, bus.din};
                        acnt_d  = '0;
                        pcnt_d  = '0;
                        state_d = DATA;
                    end else begin
                        ashd_d = {ashd_q[0], bus.din};
                        acnt_d = acnt_q + 2'd1;
                    end
                end
                DATA: begin
                    dout_d = bus.din;
                    dv_d   = 1'b1;
                    if (pcnt_q == LAST) begin
                        pcnt_d  = '0;
                        state_d = STOP;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                STOP: begin
                    // A 1 here is consumed as a bad stop bit. It does not start a new frame.
                    done_d  = ~bus.din;
                    err_d   = bus.din;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    assign bus.sel        = sel_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Self-checking bench: frame-position reference model against an 8-bit-payload sequencer and a 1-bit-payload sequencer.
module tb_demux_frame_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   use1  = 1'b0;

    logic [2:0] exp_sel  = '0;
    logic       exp_busy = 1'b0;

    demux_frame_sequencer_if ia ();
    demux_frame_sequencer_if ib ();

    demux_frame_sequencer #(.PAYLOAD_BITS(8)) u8 (.clk(clk), .rst(rst), .bus(ia.slave));
    demux_frame_sequencer #(.PAYLOAD_BITS(1)) u1 (.clk(clk), .rst(rst), .bus(ib.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic d, input logic v);
        @(negedge clk);
        ia.din = d; ia.din_valid = v;
        ib.din = d; ib.din_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_sel, input logic e_dout,
                             input logic e_dv, input logic e_busy, input logic e_done, input logic e_err);
        chk({tag, ".sel"},  use1 ? ib.sel        : ia.sel,        e_sel);
        chk({tag, ".dout"}, use1 ? ib.dout       : ia.dout,       e_dout);
        chk({tag, ".dv"},   use1 ? ib.dout_valid : ia.dout_valid, e_dv);
        chk({tag, ".busy"}, use1 ? ib.busy       : ia.busy,       e_busy);
        chk({tag, ".done"}, use1 ? ib.frame_done : ia.frame_done, e_done);
        chk({tag, ".err"},  use1 ? ib.frame_err  : ia.frame_err,  e_err);
    endtask

    // Send a frame bit by bit. The expected outputs come from each bit's position in the frame.
    // stall < 0 gives random stall gaps. nbits < 0 sends the whole frame.
    task automatic send_frame(input string tag, input logic [2:0] a, input logic [255:0] pl,
                              input int p, input logic stop, input int stall, input int nbits);
        logic bits[$];
        int   last, n, gap, strobes, dones, errs;
        logic e_dv, e_dout, e_done, e_err;
        bits.push_back(1'b1);
        for (int i = 2; i >= 0; i--) bits.push_back(a[i]);
        for (int j = p - 1; j >= 0; j--) bits.push_back(pl[j]);
        bits.push_back(stop);
        last = p + 4;
        n = (nbits < 0) ? last + 1 : nbits;
        strobes = 0; dones = 0; errs = 0;
        for (int k = 0; k < n; k++) begin
            step(bits[k], 1'b1);
            e_dv   = (k >= 4) && (k < last);
            e_dout = e_dv ? bits[k] : 1'b0;
            e_done = (k == last) && !stop;
            e_err  = (k == last) && stop;
            if (k == 3) exp_sel = a;
            exp_busy = (k < last);
            check_all(tag, exp_sel, e_dout, e_dv, exp_busy, e_done, e_err);
            strobes += int'(use1 ? ib.dout_valid : ia.dout_valid);
            dones   += int'(use1 ? ib.frame_done : ia.frame_done);
            errs    += int'(use1 ? ib.frame_err  : ia.frame_err);
            if (k < n - 1) begin
                gap = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
                for (int g = 0; g < gap; g++) begin
                    step(1'($urandom), 1'b0);
                    check_all({tag, ".stall"}, exp_sel, 1'b0, 1'b0, exp_busy, 1'b0, 1'b0);
                end
            end
        end
        if (nbits < 0) begin
            chk({tag, ".strobes"}, strobes, p);
            chk({tag, ".ndone"},   dones,   stop ? 0 : 1);
            chk({tag, ".nerr"},    errs,    stop ? 1 : 0);
        end
    endtask

    initial begin
        ia.din = 1'b0; ia.din_valid = 1'b0;
        ib.din = 1'b0; ib.din_valid = 1'b0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        send_frame("basic", 3'b101, 256'hB3, 8, 1'b0, 0, -1);
        chk("basic.busy_after", ia.busy, 1'b0);
        send_frame("stall", 3'b101, 256'hB3, 8, 1'b0, 2, -1);
        send_frame("badstop", 3'b011, 256'h5A, 8, 1'b1, 0, -1);
        send_frame("after_err", 3'b011, 256'hC3, 8, 1'b0, 0, -1);
        send_frame("b2b0", 3'b000, 256'h0F, 8, 1'b0, 0, -1);
        send_frame("b2b7", 3'b111, 256'hF0, 8, 1'b0, 0, -1);

        // Reset after 4 payload bits: start + 3 addr + 4 payload = 8 sampled bits.
        send_frame("middata", 3'b010, 256'hAA, 8, 1'b0, 0, 8);
        rst = 1'b1;
        step(1'b1, 1'b1);
        rst = 1'b0;
        exp_sel = 3'd0; exp_busy = 1'b0;
        check_all("midrst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame("fresh", 3'b110, 256'h96, 8, 1'b0, 0, -1);

        for (int r = 0; r < 6; r++)
            send_frame("rand", 3'($urandom), 256'($urandom), 8, 1'($urandom_range(0, 3) == 0), -1, -1);

        // Switch to the 1-bit-payload instance. Both instances start from reset.
        rst = 1'b1;
        step(1'b0, 1'b1);
        rst = 1'b0;
        use1 = 1'b1;
        exp_sel = 3'd0; exp_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1);
            check_all("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        send_frame("p1", 3'b100, 256'h1, 1, 1'b0, 0, -1);
        send_frame("p1b", 3'b001, 256'h0, 1, 1'b0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
